gsim_band_mvm: RTL

//  Forward banded matrix-vector multiplier, the inverse direction of the GSIM solver: b = A*x.
//  A is the fixed 16x16 symmetric heptadiagonal matrix: diag 20, off-diagonals -13/+6/-1 at distance 1/2/3.

---
 rtl/gsim_pkg.sv | 30 +++
 rtl/gsim_band_mac.sv | 22 ++
 rtl/gsim_band_mvm.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/gsim_pkg.sv
// Shared constants, band coefficients and FSM state type for the GSIM banded-matrix blocks.
package gsim_pkg;

  localparam int GSIM_N    = 16;
  localparam int GSIM_FRAC = 16;

  localparam int C0 = 20;
  localparam int C1 = -13;
  localparam int C2 = 6;
  localparam int C3 = -1;

  localparam int TAPS = 7;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CALC
  } state_t;

  // Tap d covers column offset d-3, so the band is symmetric around d=3.
  function automatic int tap_coef(input int d);
    case (d)
      0, 6:    return C3;
      1, 5:    return C2;
      2, 4:    return C1;
      default: return C0;
    endcase
  endfunction

endpackage

// File: rtl/gsim_band_mac.sv
// Combinational 7-tap band MAC: masked taps times the heptadiagonal coefficients, summed at full precision.
module gsim_band_mac
  import gsim_pkg::*;
#(
  parameter int XW = 32
) (
  input  logic signed [XW-1:0] tap_i [TAPS],
  input  logic [TAPS-1:0]      tap_vld_i,
  output logic signed [XW+5:0] s_o
);

  localparam int SW = XW + 6;

  // NOTE: always_comb outputs get a default before any conditional update, so no latch is inferred.
  always_comb begin
    s_o = '0;
    for (int d = 0; d < TAPS; d++) begin
      if (tap_vld_i[d]) s_o = s_o + (SW'(tap_i[d]) * SW'(tap_coef(d)));
    end
  end

endmodule

// File: rtl/gsim_band_mvm.sv
// Forward banded matrix-vector multiplier b = A*x for the GSIM self-test loop.
// Optional build macro GSIM_BMV_ROUND_EN selects round-half-up instead of floor for b_out.
module gsim_band_mvm
  import gsim_pkg::*;
#(
  parameter int N    = GSIM_N,
  parameter int XW   = 32,
  parameter int FRAC = GSIM_FRAC,
  parameter int BW   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 x_valid,
  input  logic signed [XW-1:0] x_in,
  output logic                 x_ready,
  output logic                 b_valid,
  output logic signed [BW-1:0] b_out,
  output logic signed [XW+5:0] b_raw
);

  localparam int SW = XW + 6;
  localparam int CW = $clog2(N);
  localparam int QW = SW - FRAC;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d, cnt_inc;
  logic                 cnt_last;
  logic                 x_ready_q, x_ready_d;
  logic                 issue_q, issue_d;
  logic [CW-1:0]        row_q;
  logic signed [XW-1:0] x_buf_q [N];
  logic                 accept;

  logic                 b_valid_q;
  logic signed [BW-1:0] b_out_q;
  logic signed [SW-1:0] b_raw_q;

  assign accept   = x_valid && x_ready_q;
  assign cnt_last = (cnt_q == CW'(N - 1));
  assign cnt_inc  = cnt_last ? '0 : cnt_q + CW'(1);

  // NOTE: sequential state uses <= so every flop samples pre-edge values together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // One counter serves both phases: load slot in IDLE/LOAD, row index in CALC.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, LOAD: begin
        if (accept) begin
          cnt_d   = cnt_inc;
          state_d = cnt_last ? CALC : LOAD;
        end
      end
      CALC: begin
        cnt_d = cnt_inc;
        if (cnt_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    x_ready_d = (state_d != CALC);
    issue_d   = (state_q == CALC);
  end

  // NOTE: x_buf is reset as well, so a stale frame can never leak into the taps after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      x_ready_q <= 1'b0;
      issue_q   <= 1'b0;
      row_q     <= '0;
      for (int i = 0; i < N; i++) x_buf_q[i] <= '0;
    end else begin
      cnt_q     <= cnt_d;
      x_ready_q <= x_ready_d;
      issue_q   <= issue_d;
      row_q     <= cnt_q;
      if (accept) x_buf_q[cnt_q] <= x_in;
    end
  end

  // Edge masking: taps whose column falls outside 0..N-1 are disabled.
  logic signed [CW+1:0] tap_idx [TAPS];
  logic signed [XW-1:0] tap     [TAPS];
  logic [TAPS-1:0]      tap_vld;

  always_comb begin
    for (int d = 0; d < TAPS; d++) begin
      tap_idx[d] = $signed({2'b00, row_q}) + (CW + 2)'(d - 3);
      tap_vld[d] = !tap_idx[d][CW+1] && (tap_idx[d] < (CW + 2)'(N));
      tap[d]     = x_buf_q[tap_idx[d][CW-1:0]];
    end
  end

  logic signed [SW-1:0] s, s_adj;
  logic signed [QW-1:0] q, q_sat;

  gsim_band_mac #(.XW(XW)) u_mac (
    .tap_i     (tap),
    .tap_vld_i (tap_vld),
    .s_o       (s)
  );

`ifdef GSIM_BMV_ROUND_EN
  localparam logic signed [SW-1:0] HALF = SW'(longint'(1) <<< (FRAC - 1));
  assign s_adj = s + HALF;
`else
  assign s_adj = s;
`endif

  localparam logic signed [QW-1:0] Q_MAX = QW'((2 ** (BW - 1)) - 1);
  localparam logic signed [QW-1:0] Q_MIN = QW'(-(2 ** (BW - 1)));

  assign q     = s_adj[SW-1:FRAC];
  assign q_sat = (q > Q_MAX) ? Q_MAX : ((q < Q_MIN) ? Q_MIN : q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_valid_q <= 1'b0;
      b_out_q   <= '0;
      b_raw_q   <= '0;
    end else begin
      b_valid_q <= issue_q;
      if (issue_q) begin
        b_out_q <= q_sat[BW-1:0];
        b_raw_q <= s;
      end
    end
  end

  assign x_ready = x_ready_q;
  assign b_valid = b_valid_q;
  assign b_out   = b_out_q;
  assign b_raw   = b_raw_q;

endmodule
